// File: rtl/sram_bist_pkg.sv
// Shared types and March C- tables for the SRAM BIST controller and its compare stage.
package sram_bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef enum logic {RD = 1'b0, WR = 1'b1} op_e;

  localparam logic [2:0] E0 = 3'd0;
  localparam logic [2:0] E1 = 3'd1;
  localparam logic [2:0] E2 = 3'd2;
  localparam logic [2:0] E3 = 3'd3;
  localparam logic [2:0] E4 = 3'd4;
  localparam logic [2:0] E5 = 3'd5;

  // Bit i describes element i: descending order, read expects ~B, write stores ~B.
  localparam logic [5:0] ELEM_DOWN   = 6'b01_1000;
  localparam logic [5:0] ELEM_RD_INV = 6'b01_0100;
  localparam logic [5:0] ELEM_WR_INV = 6'b00_1010;

  localparam logic [7:0] BG_TABLE [4] = '{8'h00, 8'h55, 8'h33, 8'h0F};

  function automatic logic elem_two_op(input logic [2:0] e);
    return (e != E0) && (e != E5);
  endfunction

  function automatic op_e elem_first_op(input logic [2:0] e);
    return (e == E0) ? WR : RD;
  endfunction

endpackage

// File: rtl/sram_bist_cmp.sv
// Read-data checker: carries expected data and location one cycle beside each read,
// then compares against the macro output and holds the first mismatch.
module sram_bist_cmp
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              rd_issue_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        elem_i,
  input  logic [1:0]        bg_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              fail_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [2:0]        fail_elem_o,
  output logic [1:0]        fail_bg_o,
  output logic [DATA_W-1:0] fail_syn_o
);

  logic              vld_q;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        elem_q;
  logic [1:0]        bg_q;
  logic [DATA_W-1:0] syn;
  logic              mismatch;

  assign syn      = exp_q ^ rdata_i;
  assign mismatch = vld_q && (syn != '0);

  // NOTE: payload registers carry no reset; vld_q alone decides whether they are looked at.
  always_ff @(posedge clk) begin
    exp_q  <= exp_i;
    addr_q <= addr_i;
    elem_q <= elem_i;
    bg_q   <= bg_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= 1'b0;
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_elem_o <= E0;
      fail_bg_o   <= '0;
      fail_syn_o  <= '0;
    end else begin
      vld_q <= rd_issue_i;
      if (clr_i) begin
        fail_o      <= 1'b0;
        fail_addr_o <= '0;
        fail_elem_o <= E0;
        fail_bg_o   <= '0;
        fail_syn_o  <= '0;
      end else if (mismatch && !fail_o) begin
        fail_o      <= 1'b1;
        fail_addr_o <= addr_q;
        fail_elem_o <= elem_q;
        fail_bg_o   <= bg_q;
        fail_syn_o  <= syn;
      end
    end
  end

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller for the single-port SRAM BIST port.
// Define SRAM_BIST_BACKGROUNDS_EN to repeat the march over four data backgrounds.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [1:0]        fail_bg,
  output logic [DATA_W-1:0] fail_syn,
  output logic              bist_en,
  output logic              bist_men,
  output logic              bist_wen,
  output logic              bist_ren,
  output logic [ADDR_W-1:0] bist_addr,
  output logic [DATA_W-1:0] bist_din,
  output logic [DATA_W-1:0] bist_bm,
  input  logic [DATA_W-1:0] sram_dout
);

`ifdef SRAM_BIST_BACKGROUNDS_EN
  localparam logic [1:0] BG_LAST = 2'd3;
`else
  localparam logic [1:0] BG_LAST = 2'd0;
`endif
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  function automatic logic [DATA_W-1:0] bg_word(input logic [1:0] idx);
    logic [7:0]        pat;
    logic [DATA_W-1:0] w;
    pat = BG_TABLE[idx];
    for (int i = 0; i < DATA_W; i++) w[i] = pat[i % 8];
    return w;
  endfunction

  state_e            state_q;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  op_e               op_q, op_d;
  logic [1:0]        bg_q, bg_d;
  logic              last_op;
  logic [ADDR_W-1:0] end_addr;
  logic [DATA_W-1:0] bg_word_d, wr_data, exp_data;
  logic              busy_q, done_q;
  logic              en_q, men_q, wen_q, ren_q;
  logic [ADDR_W-1:0] baddr_q;
  logic [DATA_W-1:0] din_q, bm_q;
  logic [1:0]        cmp_bg;

  assign end_addr  = ELEM_DOWN[elem_q] ? '0 : ADDR_MAX;
  assign bg_word_d = bg_word(bg_d);
  assign wr_data   = ELEM_WR_INV[elem_d] ? ~bg_word_d : bg_word_d;
  assign exp_data  = ELEM_RD_INV[elem_q] ? ~bg_word(bg_q) : bg_word(bg_q);

  // Successor of the op currently on the bus.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    elem_d  = elem_q;
    addr_d  = addr_q;
    op_d    = op_q;
    bg_d    = bg_q;
    last_op = 1'b0;
    if (op_q == RD && elem_two_op(elem_q)) begin
      op_d = WR;
    end else if (addr_q == end_addr) begin
      if (elem_q == E5) begin
        if (bg_q == BG_LAST) begin
          last_op = 1'b1;
        end else begin
          bg_d   = bg_q + 2'd1;
          elem_d = E0;
          addr_d = '0;
          op_d   = WR;
        end
      end else begin
        elem_d = elem_q + 3'd1;
        addr_d = ELEM_DOWN[elem_d] ? ADDR_MAX : '0;
        op_d   = elem_first_op(elem_d);
      end
    end else begin
      addr_d = ELEM_DOWN[elem_q] ? addr_q - 1'b1 : addr_q + 1'b1;
      op_d   = elem_first_op(elem_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      elem_q  <= E0;
      addr_q  <= '0;
      op_q    <= WR;
      bg_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      men_q   <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      baddr_q <= '0;
      din_q   <= '0;
      bm_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            elem_q  <= E0;
            addr_q  <= '0;
            op_q    <= WR;
            bg_q    <= '0;
            en_q    <= 1'b1;
            men_q   <= 1'b1;
            wen_q   <= 1'b1;
            ren_q   <= 1'b0;
            baddr_q <= '0;
            din_q   <= bg_word(2'd0);
            bm_q    <= '1;
          end
        end
        RUN: begin
          if (last_op) begin
            state_q <= DRAIN;
            en_q    <= 1'b0;
            men_q   <= 1'b0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            baddr_q <= '0;
            din_q   <= '0;
            bm_q    <= '0;
          end else begin
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            bg_q    <= bg_d;
            wen_q   <= (op_d == WR);
            ren_q   <= (op_d == RD);
            baddr_q <= addr_d;
            din_q   <= (op_d == WR) ? wr_data : '0;
          end
        end
        DRAIN: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE: begin
          if (!start) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SRAM_BIST_BACKGROUNDS_EN
  assign cmp_bg = bg_q;
`else
  assign cmp_bg = 2'b00;
`endif

  sram_bist_cmp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_cmp (
    .clk        (clk),
    .rst        (rst),
    .clr_i      ((state_q == IDLE) && start),
    .rd_issue_i (ren_q),
    .exp_i      (exp_data),
    .addr_i     (addr_q),
    .elem_i     (elem_q),
    .bg_i       (cmp_bg),
    .rdata_i    (sram_dout),
    .fail_o     (fail),
    .fail_addr_o(fail_addr),
    .fail_elem_o(fail_elem),
    .fail_bg_o  (fail_bg),
    .fail_syn_o (fail_syn)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign bist_en   = en_q;
  assign bist_men  = men_q;
  assign bist_wen  = wen_q;
  assign bist_ren  = ren_q;
  assign bist_addr = baddr_q;
  assign bist_din  = din_q;
  assign bist_bm   = bm_q;

endmodule
